// File: rtl/sobel_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_frame_sched
//  Description : Frame-level scheduler for the sobel_0_obf core. Round-robin
//                arbitration between two ping-pong frame buffers, ap_start /
//                ap_done handshake, bank select, working_key hold for the
//                whole run, and run-length measurement.
//                Optional watchdog abort: define SOBEL_SCHED_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_frame_sched #(
    parameter logic [31:0] WDOG_LIMIT = 32'd300000,
    parameter int          CNT_W      = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [1:0]       req,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             err,
    output logic             busy,
    output logic             buf_sel,
    input  logic             key_wr,
    input  logic [2:0]       key_din,
    output logic [2:0]       working_key,
    output logic             core_start,
    input  logic             core_done,
    output logic             core_rst,
    output logic [CNT_W-1:0] last_cycles
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DONE  = 4'b0100,
        ST_ABORT = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,       state_d;
    logic [1:0]       grant_q,       grant_d;
    logic [1:0]       done_q,        done_d;
    logic             buf_sel_q,     buf_sel_d;
    logic [2:0]       working_key_q, working_key_d;
    logic [2:0]       key_reg_q,     key_reg_d;
    logic             core_start_q,  core_start_d;
    logic [CNT_W-1:0] last_cycles_q, last_cycles_d;
    logic [CNT_W-1:0] run_cnt_q,     run_cnt_d;
    logic             rr_q,          rr_d;

    logic             w_win;
    logic [CNT_W-1:0] w_run_cnt_inc;

`ifdef SOBEL_SCHED_WDOG_EN
    localparam logic [CNT_W-1:0] c_wdog_limit = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] c_wdog_last  = CNT_W'(WDOG_LIMIT - 32'd1);

    logic err_q,      err_d;
    logic core_rst_q, core_rst_d;

    assign err      = err_q;
    assign core_rst = core_rst_q;
`else
    // Watchdog not built: the limit parameter has no consumer.
    logic unused_wdog;
    assign unused_wdog = ^WDOG_LIMIT;

    assign err      = 1'b0;
    assign core_rst = 1'b0;
`endif

    // Winner selection and saturating run-counter increment.
    always_comb begin
        w_win         = req[rr_q] ? rr_q : ~rr_q;
        w_run_cnt_inc = (&run_cnt_q) ? run_cnt_q : (run_cnt_q + c_cnt_one);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = 2'b00;
        buf_sel_d     = buf_sel_q;
        working_key_d = working_key_q;
        key_reg_d     = key_wr ? key_din : key_reg_q;
        core_start_d  = core_start_q;
        last_cycles_d = last_cycles_q;
        run_cnt_d     = run_cnt_q;
        rr_d          = rr_q;
`ifdef SOBEL_SCHED_WDOG_EN
        err_d         = 1'b0;
        core_rst_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d       = w_win ? 2'b10 : 2'b01;
                    buf_sel_d     = w_win;
                    // Key is latched only here so a mid-run write never
                    // disturbs the frame in progress.
                    working_key_d = key_reg_q;
                    core_start_d  = 1'b1;
                    run_cnt_d     = '0;
                    rr_d          = ~w_win;
                    state_d       = ST_RUN;
                end
            end

            ST_RUN: begin
                run_cnt_d = w_run_cnt_inc;
                // core_done is checked first so it wins over a watchdog
                // expiry in the same cycle.
                if (core_done) begin
                    core_start_d  = 1'b0;
                    last_cycles_d = w_run_cnt_inc;
                    done_d        = buf_sel_q ? 2'b10 : 2'b01;
                    state_d       = ST_DONE;
                end
`ifdef SOBEL_SCHED_WDOG_EN
                else if (run_cnt_q == c_wdog_last) begin
                    core_start_d  = 1'b0;
                    core_rst_d    = 1'b1;
                    last_cycles_d = c_wdog_limit;
                    done_d        = buf_sel_q ? 2'b10 : 2'b01;
                    err_d         = 1'b1;
                    state_d       = ST_ABORT;
                end
`endif
            end

            ST_DONE: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end

`ifdef SOBEL_SCHED_WDOG_EN
            ST_ABORT: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
`endif

            default: begin
                grant_d      = 2'b00;
                core_start_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            done_q        <= 2'b00;
            buf_sel_q     <= 1'b0;
            working_key_q <= 3'b000;
            key_reg_q     <= 3'b000;
            core_start_q  <= 1'b0;
            last_cycles_q <= '0;
            run_cnt_q     <= '0;
            rr_q          <= 1'b0;
`ifdef SOBEL_SCHED_WDOG_EN
            err_q         <= 1'b0;
            core_rst_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            buf_sel_q     <= buf_sel_d;
            working_key_q <= working_key_d;
            key_reg_q     <= key_reg_d;
            core_start_q  <= core_start_d;
            last_cycles_q <= last_cycles_d;
            run_cnt_q     <= run_cnt_d;
            rr_q          <= rr_d;
`ifdef SOBEL_SCHED_WDOG_EN
            err_q         <= err_d;
            core_rst_q    <= core_rst_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign buf_sel     = buf_sel_q;
    assign working_key = working_key_q;
    assign core_start  = core_start_q;
    assign last_cycles = last_cycles_q;

endmodule
`default_nettype wire

// File: doc/sobel_frame_sched.md
# sobel_frame_sched

Frame-level scheduler for the `sobel_0_obf` core. It arbitrates frame requests from two requesters (ping-pong frame buffers 0/1) with round-robin, runs the core's ap_start/ap_done handshake, and selects the buffer bank for the core's memory ports. It holds the obfuscation `working_key` stable for the whole run and measures run length. An optional watchdog aborts hung runs.

## Interface
Parameters:
- `WDOG_LIMIT`, default 32'd300000: maximum run length in cycles before abort. Used only with `SOBEL_SCHED_WDOG_EN`.
- `CNT_W`, default 32: width of the run-cycle counter.

Ports:
- `ap_clk` in 1: single clock.
- `ap_rst` in 1: synchronous, active-high reset.
- `req` in 2: level request per requester. Held until that requester's `done` pulse.
- `grant` out 2: one-hot; identifies the requester being served. Registered.
- `done` out 2: one-cycle pulse when the served requester's frame finishes or is aborted.
- `err` out 1: valid with `done`. 1 means the frame was aborted by the watchdog.
- `busy` out 1: high while a frame is in progress (any state except IDLE).
- `buf_sel` out 1: index of the granted requester. Drives the indata/outdata bank mux.
- `key_wr` in 1: write strobe for `key_din`.
- `key_din` in 3: new key value.
- `working_key` out 3: key driven to the core. Updated only at grant.
- `core_start` out 1: connects to core ap_start.
- `core_done` in 1: connects to core ap_done.
- `core_rst` out 1: OR'd with `ap_rst` to form the core reset. Used for watchdog abort.
- `last_cycles` out CNT_W: run length of the last completed frame.

## Operation
- FSM states: IDLE, RUN, DONE, ABORT. One-hot encoding.
- **IDLE**
  - If any `req` bit is set, pick the winner by priority pointer `rr`. Requester `rr` wins if it is requesting; otherwise the other requester wins.
  - On the winning transition, register: `grant`, `buf_sel`, `working_key <= key_reg`, `core_start <= 1`.
  - Clear `run_cnt` to 0 and set `rr` to the index of the non-winner.
  - Go to RUN.
- **RUN**
  - `run_cnt` increments every cycle and saturates at all-ones.
  - When `core_done` = 1: `core_start <= 0`, `last_cycles <= run_cnt+1`, go to DONE.
  - Watchdog (macro on): if `run_cnt == WDOG_LIMIT-1` and `core_done` = 0, then `core_start <= 0`, `core_rst <= 1`, go to ABORT.
  - If `core_done` and the watchdog limit occur in the same cycle, `core_done` wins.
- **DONE**: `done[buf_sel]` = 1, `err` = 0, then go to IDLE. `grant` clears on exit.
- **ABORT**
  - `core_rst` = 1 for exactly this one cycle.
  - `done[buf_sel]` = 1 and `err` = 1.
  - `last_cycles <= WDOG_LIMIT`.
  - Go to IDLE.
- `key_reg` is written whenever `key_wr` = 1, in any state. A write during RUN does not change `working_key` until the next grant.
- If `req` drops during RUN, the run is not cancelled. It completes and `done` still pulses.
- If `req` drops in IDLE before being sampled, it is ignored.
- Reset values: `grant`=0, `done`=0, `err`=0, `busy`=0, `buf_sel`=0, `working_key`=0, `key_reg`=0, `core_start`=0, `core_rst`=0, `last_cycles`=0, `rr`=0, state=IDLE.
- `ap_rst` mid-run returns everything to reset values. No `done` is issued. The core shares `ap_rst`, so it resets too.

## Timing
- `req` sampled high in IDLE at cycle t: `grant` and `core_start` are high at t+1.
- `core_done` high at cycle d: `core_start` is low at d+1, so the core does not restart. `done` pulses at d+1. State is IDLE at d+2.
- A requester must deassert `req` by cycle d+1. If `req` is still high at d+2, it is a new request.
- Back-to-back frames: the next `core_start` can rise at d+3 at the earliest.
- `last_cycles` equals the number of cycles `core_start` was high.
- `core_start` stays high through RUN, including the `core_done` cycle. The core's ap_ready coincides with ap_done.

## Configuration
- `SOBEL_SCHED_WDOG_EN` defined:
  - Watchdog, ABORT state and `core_rst` pulse are implemented.
  - `err` can assert.
- `SOBEL_SCHED_WDOG_EN` undefined:
  - No ABORT state.
  - `core_rst` and `err` are tied to 0.
  - RUN waits indefinitely for `core_done`.
  - `WDOG_LIMIT` is unused.

## Test plan
- After reset, hold `req`=01 and model `core_done` at the 10th cycle of `core_start` high.
  - `grant`=01 one cycle after `req`.
  - `done`=01 pulse with `err`=0.
  - `last_cycles`=10.
  - `core_start` low the cycle after `core_done`.
- Hold `req`=11 continuously, with each requester dropping `req` on its `done`.
  - Grants go 01, then 10.
  - Re-raising both gives 01 next.
  - No requester is served twice in a row while the other is waiting.
- `key_din`=3'b101 written before a frame, then `key_din`=3'b010 written mid-run.
  - `working_key`=101 for the whole run.
  - `working_key`=010 at the next grant.
- With the macro on, `WDOG_LIMIT`=16, core never asserts done.
  - `core_rst` pulses for one cycle after 16 RUN cycles.
  - `done` and `err`=1 in that same cycle.
  - `last_cycles`=16.
  - Back in IDLE the next cycle.
- With the macro on, `WDOG_LIMIT`=16, `core_done` asserted in the 16th cycle: normal DONE, `err`=0, no `core_rst`.
- Assert `ap_rst` for one cycle mid-RUN.
  - Every output returns to its reset value the next cycle.
  - No `done` pulse.
  - A held `req` is re-granted starting from priority 0.
